alu_issue_decoder: RTL and testbench
====================================

Name: alu_issue_decoder

Overview:
- Decode/issue stage that produces the 4-bit ALU operation codes consumed by the core's combinational ALU.
- Accepts RV32I instruction words over a valid/ready handshake and decodes opcode/funct3/funct7 into: ALU op, operand-B select, immediate, branch condition type and register fields.
- Results are held in a 2-entry skid-buffered output stage feeding the execute stage.
- Sits between fetch and execute; also counts issued instructions.

Parameters:
- CNT_W, 32, width of issue_count.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  instruction word
- in_pc  in  32  PC of instruction; passed through unchanged
- out_valid  out  1  decoded entry valid
- out_ready  in  1  execute stage accepts entry
- out_alu_op  out  4  ALU op code
- out_use_imm  out  1  1 = operand B is out_imm, 0 = rs2 data
- out_imm  out  32  decoded immediate
- out_br_type  out  3  000 none, 001 eq, 010 ne, 011 lt, 100 ge
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_reg_write  out  1  writes rd
- out_illegal  out  1  undecodable instruction
- out_pc  out  32  PC of entry
- issue_count  out  CNT_W  count of completed output handshakes

Behaviour:
- Reset (rst=1 at posedge):
  - both entries invalid; out_valid=0; all out_* data fields=0; issue_count=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after.
- ALU op codes:
  - add 0010, sub 0110, and 0000, or 0001, xor 0011
  - sll 0100, srl 0101, sra 1001
  - unsigned compare (sltu/bltu/bgeu) 0111, signed compare (slt/blt/bge) 1000
- R-type (opcode 0110011):
  - funct3 000: funct7 0000000 gives add, 0100000 gives sub.
  - funct3 111 and, 110 or, 100 xor, 001 sll, 101 srl/sra (by funct7), 010 slt, 011 sltu.
  - use_imm=0, reg_write=1.
- I-type ALU (opcode 0010011):
  - Same funct3 map as R-type, with addi in place of add/sub.
  - imm = sign-extended instr[31:20].
  - Shifts: imm = zero-extended instr[24:20]; funct7 must be 0000000, except srai which uses 0100000.
  - use_imm=1, reg_write=1.
- lw (0000011, funct3 010):
  - add, I-immediate, use_imm=1, reg_write=1.
- sw (0100011, funct3 010):
  - add, S-immediate {instr[31:25],instr[11:7]} sign-extended, use_imm=1, reg_write=0.
- Branch (1100011):
  - beq: sub, eq. bne: sub, ne.
  - blt: 1000, lt. bge: 1000, ge.
  - bltu: 0111, lt. bgeu: 0111, ge.
  - imm = B-immediate sign-extended, bit0 = 0.
  - use_imm=0, reg_write=0.
- Illegal: any other opcode/funct combination gives illegal=1, alu_op=0010, use_imm=0, reg_write=0, br_type=000.
- rd/rs1/rs2 are always the raw fields instr[11:7], [19:15], [24:20].
- Pipeline and handshake:
  - Main entry M drives out_*; skid entry S.
  - Input accepted when in_valid && in_ready. Output handshake when out_valid && out_ready.
  - Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 if M is free or draining.
  - Throughput is 1 per cycle while out_ready=1.
  - in_ready = !S_valid, registered.
  - Accepted word goes to M if M is empty or M drains this cycle and S is empty; otherwise it goes to S.
  - On output handshake with S valid, S moves to M.
  - Order strictly preserved.
  - out_* fields stable while out_valid=1 and out_ready=0.
  - issue_count increments by 1 per output handshake and wraps at 2^CNT_W.
- flush:
  - Next cycle: M and S invalid, out_valid=0, in_ready=1.
  - Input presented in the flush cycle is dropped.
  - issue_count is not incremented for an output handshake in the flush cycle; flush wins.
- Reset mid-operation: same as reset; buffered entries are lost and rst has priority over flush.

Test Plan:
- add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle: alu_op=0010, rd=3, rs1=1, rs2=2, use_imm=0, reg_write=1, br_type=000; issue_count=1.
- srai x5,x6,3 (0x40335293) -> alu_op=1001, use_imm=1, imm=0x00000003, rd=5.
- bge x1,x2,-8 (0xFE20DCE3) -> alu_op=1000, br_type=100, imm=0xFFFFFFF8, reg_write=0.
- Three back-to-back valid words with out_ready=0:
  - first goes to M, second to S; in_ready=0 from cycle after the second accept; third held.
  - Raise out_ready -> all three emitted in order on consecutive cycles; issue_count=3.
- M and S full, in_valid=1, flush=1 -> next cycle out_valid=0, in_ready=1, issue_count unchanged.
- 0x0000007F -> illegal=1, alu_op=0010, reg_write=0.
- rst asserted mid-stream -> all outputs zero next cycle.

Source files
------------

// File: rtl/alu_issue_decoder.sv
// RV32I decode/issue stage: decodes instruction words into ALU control,
// immediate, branch type and register fields, and buffers the results in a
// two-entry skid stage (main entry M drives out_*, skid entry S) toward execute.
module alu_issue_decoder #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_alu_op,
   output logic             out_use_imm,
   output logic [31:0]      out_imm,
   output logic [2:0]       out_br_type,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic             out_reg_write,
   output logic             out_illegal,
   output logic [31:0]      out_pc,
   output logic [CNT_W-1:0] issue_count
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b001;
   localparam logic [2:0] BR_NE   = 3'b010;
   localparam logic [2:0] BR_LT   = 3'b011;
   localparam logic [2:0] BR_GE   = 3'b100;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic        use_imm;
      logic [31:0] imm;
      logic [2:0]  br_type;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        reg_write;
      logic        illegal;
      logic [31:0] pc;
   } entry_t;

   entry_t           dec;
   entry_t           m_ent;
   entry_t           s_ent;
   logic             m_valid;
   logic             s_valid;
   logic             s_valid_nxt;
   logic             rdy_q;
   logic             acc;
   logic             hs;
   logic             legal;
   logic [6:0]       opc;
   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [CNT_W-1:0] cnt;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];

   // Combinational decode of the incoming word; illegal words get a harmless add.
   always_comb begin
      dec       = '0;
      legal     = 1'b0;
      dec.rd    = in_instr[11:7];
      dec.rs1   = in_instr[19:15];
      dec.rs2   = in_instr[24:20];
      dec.pc    = in_pc;
      dec.alu_op = ALU_ADD;
      case (opc)
         OPC_R: begin
            dec.reg_write = 1'b1;
            legal = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            case (f3)
               3'b000:  dec.alu_op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
               3'b001:  dec.alu_op = ALU_SLL;
               3'b010:  dec.alu_op = ALU_SLT;
               3'b011:  dec.alu_op = ALU_SLTU;
               3'b100:  dec.alu_op = ALU_XOR;
               3'b101:  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               3'b110:  dec.alu_op = ALU_OR;
               default: dec.alu_op = ALU_AND;
            endcase
         end
         OPC_I: begin
            dec.reg_write = 1'b1;
            dec.use_imm   = 1'b1;
            dec.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
            legal         = 1'b1;
            case (f3)
               3'b000:  dec.alu_op = ALU_ADD;
               3'b001: begin
                  dec.alu_op = ALU_SLL;
                  dec.imm    = {27'd0, in_instr[24:20]};
                  legal      = (f7 == F7_ZERO);
               end
               3'b010:  dec.alu_op = ALU_SLT;
               3'b011:  dec.alu_op = ALU_SLTU;
               3'b100:  dec.alu_op = ALU_XOR;
               3'b101: begin
                  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  dec.imm    = {27'd0, in_instr[24:20]};
                  legal      = (f7 == F7_ZERO) || (f7 == F7_ALT);
               end
               3'b110:  dec.alu_op = ALU_OR;
               default: dec.alu_op = ALU_AND;
            endcase
         end
         OPC_LOAD: begin
            legal         = (f3 == 3'b010);
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
            dec.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OPC_STORE: begin
            legal       = (f3 == 3'b010);
            dec.use_imm = 1'b1;
            dec.imm     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OPC_BRANCH: begin
            legal   = 1'b1;
            dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
            case (f3)
               3'b000:  begin dec.alu_op = ALU_SUB;  dec.br_type = BR_EQ; end
               3'b001:  begin dec.alu_op = ALU_SUB;  dec.br_type = BR_NE; end
               3'b100:  begin dec.alu_op = ALU_SLT;  dec.br_type = BR_LT; end
               3'b101:  begin dec.alu_op = ALU_SLT;  dec.br_type = BR_GE; end
               3'b110:  begin dec.alu_op = ALU_SLTU; dec.br_type = BR_LT; end
               3'b111:  begin dec.alu_op = ALU_SLTU; dec.br_type = BR_GE; end
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.alu_op    = ALU_ADD;
         dec.use_imm   = 1'b0;
         dec.imm       = '0;
         dec.br_type   = BR_NONE;
         dec.reg_write = 1'b0;
      end
      dec.illegal = !legal;
   end

   assign in_ready = rdy_q & ~rst;
   assign acc      = in_valid & in_ready;
   assign hs       = m_valid & out_ready;

   // Skid occupancy after this cycle; in_ready next cycle is its inverse.
   always_comb begin
      s_valid_nxt = s_valid;
      if (hs && s_valid)
         s_valid_nxt = 1'b0;
      else if (acc && m_valid && !hs)
         s_valid_nxt = 1'b1;
   end

   // Two-entry buffer, ready flag and issue counter; rst beats flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_ent   <= '0;
         s_ent   <= '0;
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         rdy_q   <= 1'b1;
         cnt     <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         if (hs)
            cnt <= cnt + CNT_W'(1);
         if (hs && s_valid) begin
            m_ent <= s_ent;
         end else if (acc && (!m_valid || hs)) begin
            m_ent   <= dec;
            m_valid <= 1'b1;
         end else if (acc) begin
            s_ent <= dec;
         end else if (hs) begin
            m_valid <= 1'b0;
         end
         s_valid <= s_valid_nxt;
         rdy_q   <= !s_valid_nxt;
      end
   end

   assign out_valid     = m_valid;
   assign out_alu_op    = m_ent.alu_op;
   assign out_use_imm   = m_ent.use_imm;
   assign out_imm       = m_ent.imm;
   assign out_br_type   = m_ent.br_type;
   assign out_rd        = m_ent.rd;
   assign out_rs1       = m_ent.rs1;
   assign out_rs2       = m_ent.rs2;
   assign out_reg_write = m_ent.reg_write;
   assign out_illegal   = m_ent.illegal;
   assign out_pc        = m_ent.pc;
   assign issue_count   = cnt;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Bench for alu_issue_decoder: randomized and directed stimulus, expected
// decodes queued on input acceptance and checked by a negedge monitor.
module tb_alu_issue_decoder;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_instr, in_pc;
   logic [3:0]  out_alu_op;
   logic        out_use_imm, out_reg_write, out_illegal;
   logic [31:0] out_imm, out_pc;
   logic [2:0]  out_br_type;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [31:0] issue_count;

   alu_issue_decoder #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_op(out_alu_op), .out_use_imm(out_use_imm), .out_imm(out_imm),
      .out_br_type(out_br_type), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_reg_write(out_reg_write), .out_illegal(out_illegal), .out_pc(out_pc),
      .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  alu;
      logic        ui;
      logic [31:0] imm;
      logic [2:0]  br;
      logic [4:0]  rd, rs1, rs2;
      logic        rw, ill;
      logic [31:0] pc;
   } exp_t;

   exp_t        q[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] exp_cnt = 0;
   bit          prev_rst = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
   endtask

   // Reference decode written from the instruction-set rules with arithmetic immediates.
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      int   opc = int'(w[6:0]);
      int   f3  = int'(w[14:12]);
      int   f7  = int'(w[31:25]);
      int   iimm = $signed(w) >>> 20;
      int   simm = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
      int   bimm = (($signed(w) >>> 31) * 4096) + int'(w[7]) * 2048
                   + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      bit   ok = 0;
      int   op = 2, imm = 0, br = 0;
      bit   ui = 0, rw = 0;
      int   rtab[8] = '{2, 4, 8, 7, 3, 5, 1, 0};
      if (opc == 'h33) begin
         ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
         op = rtab[f3];
         if (f7 == 'h20) op = (f3 == 0) ? 6 : 9;
         rw = 1;
      end else if (opc == 'h13) begin
         ok = 1;
         op = rtab[f3];
         imm = iimm;
         if (f3 == 1) begin ok = (f7 == 0); imm = int'(w[24:20]); end
         if (f3 == 5) begin
            ok = (f7 == 0) || (f7 == 'h20);
            imm = int'(w[24:20]);
            if (f7 == 'h20) op = 9;
         end
         ui = 1; rw = 1;
      end else if (opc == 'h03) begin
         ok = (f3 == 2); imm = iimm; ui = 1; rw = 1;
      end else if (opc == 'h23) begin
         ok = (f3 == 2); imm = simm; ui = 1;
      end else if (opc == 'h63) begin
         ok = !(f3 == 2 || f3 == 3);
         imm = bimm;
         op = (f3 < 2) ? 6 : (f3 < 6) ? 8 : 7;
         br = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 4 || f3 == 6) ? 3 : 4;
      end
      if (!ok) begin op = 2; imm = 0; br = 0; ui = 0; rw = 0; end
      e.alu = op[3:0]; e.ui = ui; e.imm = imm; e.br = br[2:0];
      e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
      e.rw = rw; e.ill = !ok; e.pc = pc;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 9);
      int f = $urandom_range(0, 3);
      logic [6:0] f7 = (f == 0) ? 7'h20 : (f == 3) ? 7'($urandom) : 7'h00;
      if (k <= 2) begin w[6:0] = 7'h33; w[31:25] = f7; end
      else if (k <= 4) begin w[6:0] = 7'h13; if (w[13:12] == 2'b01) w[31:25] = f7; end
      else if (k == 5) begin w[6:0] = 7'h03; if (f != 3) w[14:12] = 3'b010; end
      else if (k == 6) begin w[6:0] = 7'h23; if (f != 3) w[14:12] = 3'b010; end
      else if (k <= 8) w[6:0] = 7'h63;
      return w;
   endfunction

   // Monitor: occupancy-based handshake checks, head-of-queue data compare, counter model.
   always @(negedge clk) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && q.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("issue_count", issue_count, exp_cnt);
      if (prev_rst) begin
         chk("rst_alu_op", {28'd0, out_alu_op}, 32'd0);
         chk("rst_imm", out_imm, 32'd0);
         chk("rst_pc", out_pc, 32'd0);
         chk("rst_regs", {17'd0, out_rd, out_rs1, out_rs2}, 32'd0);
         chk("rst_flags", {27'd0, out_use_imm, out_br_type, out_reg_write, out_illegal}, 32'd0);
      end
      if (out_valid && q.size() > 0) begin
         chk("alu_op", {28'd0, out_alu_op}, {28'd0, q[0].alu});
         chk("use_imm", {31'd0, out_use_imm}, {31'd0, q[0].ui});
         chk("imm", out_imm, q[0].imm);
         chk("br_type", {29'd0, out_br_type}, {29'd0, q[0].br});
         chk("regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, q[0].rd, q[0].rs1, q[0].rs2});
         chk("reg_write", {31'd0, out_reg_write}, {31'd0, q[0].rw});
         chk("illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
         chk("pc", out_pc, q[0].pc);
      end
      if (rst) begin
         q.delete();
         exp_cnt = 0;
      end else if (flush) begin
         q.delete();
      end else if (out_valid && out_ready) begin
         if (q.size() > 0) void'(q.pop_front());
         exp_cnt = exp_cnt + 1;
      end
      prev_rst = rst;
   end

   // One clock of stimulus; the accepted word's expected decode is queued after sampling.
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rs);
      @(posedge clk);
      #1;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = rs;
      @(negedge clk);
      #1;
      if (in_valid && in_ready && !flush && !rst) q.push_back(model(in_instr, in_pc));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'd0; in_pc = 32'd0;
      repeat (3) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      idle(1);

      // add x3,x1,x2
      cyc(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("add_valid", {31'd0, out_valid}, 32'd1);
      chk("add_alu_op", {28'd0, out_alu_op}, 32'h2);
      chk("add_regs", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
      chk("add_flags", {29'd0, out_use_imm, out_reg_write, out_br_type == 3'd0}, 32'b011);
      idle(1);
      chk("add_count", issue_count, 32'd1);

      // srai x5,x6,3
      cyc(1'b1, 32'h40335293, 32'h104, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("srai_alu_op", {28'd0, out_alu_op}, 32'h9);
      chk("srai_imm", out_imm, 32'h3);
      chk("srai_rd", {27'd0, out_rd}, 32'd5);

      // bge x1,x2,-8
      cyc(1'b1, 32'hFE20DCE3, 32'h108, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("bge_alu_op", {28'd0, out_alu_op}, 32'h8);
      chk("bge_br", {29'd0, out_br_type}, 32'd4);
      chk("bge_imm", out_imm, 32'hFFFFFFF8);
      chk("bge_rw", {31'd0, out_reg_write}, 32'd0);

      // illegal opcode
      cyc(1'b1, 32'h0000007F, 32'h10C, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("ill_flag", {31'd0, out_illegal}, 32'd1);
      chk("ill_alu_op", {28'd0, out_alu_op}, 32'h2);
      chk("ill_rw", {31'd0, out_reg_write}, 32'd0);
      idle(2);

      // three words with execute stalled, then released
      cyc(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h40335293, 32'h204, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hFE20DCE3, 32'h208, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      cyc(1'b1, 32'hFE20DCE3, 32'h208, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'hFE20DCE3, 32'h208, 1'b1, 1'b0, 1'b0);
      idle(3);

      // flush with both entries full and a word presented
      cyc(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h002081B3, 32'h304, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h002081B3, 32'h308, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);

      // reset mid-stream
      cyc(1'b1, 32'h40335293, 32'h400, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hFE20DCE3, 32'h404, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h0000007F, 32'h408, 1'b1, 1'b1, 1'b1);
      idle(1);
      chk("rst_count", issue_count, 32'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
             $urandom_range(0, 299) == 0);
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
